tcp_tx_payload_fetch: RTL and testbench
=======================================

// Module: tcp_tx_payload_fetch
// PURPOSE
// - Stage directly downstream of the TCP TX engine. It accepts one header descriptor per packet:
//   flowid, tcp_pkt_hdr, src/dst IP and payload_buf_struct.
// - It forwards the header metadata to the IP/Ethernet encapsulation path, then reads the payload
//   from the TX payload buffer and streams it out as DATA_W-wide beats with last/padbytes framing.
// - One packet in flight; header and payload outputs are strictly ordered per packet.
// PARAMETERS
// - DATA_W     512                   payload stream / buffer read width in bits; power of 2, >=64
// - BYTES_W    $clog2(DATA_W/8)      width of padbytes; derived, not overridden
// PORTS
// - clk                 in   1                   clock
// - rst                 in   1                   asynchronous, active-low reset (asserted when 0)
// - tx_pkt_hdr_val      in   1                   header descriptor valid
// - tx_pkt_flowid       in   FLOWID_W            flow id
// - tx_pkt_hdr          in   TCP_PKT_HDR_W       tcp_pkt_hdr struct
// - tx_pkt_src_ip_addr  in   IP_ADDR_W           source IP
// - tx_pkt_dst_ip_addr  in   IP_ADDR_W           destination IP
// - tx_pkt_payload      in   PAYLOAD_BUF_STRUCT_W payload_buf_struct {addr, size}; size in bytes
// - tx_pkt_hdr_rdy      out  1                   descriptor accepted
// - fetch_meta_val      out  1                   metadata valid
// - fetch_meta_data     out  TX_META_STRUCT_W    tx_meta_struct {flowid, hdr, src_ip, dst_ip, payload_len}
// - fetch_meta_rdy      in   1                   metadata consumed
// - fetch_buf_rd_req_val   out 1                 payload buffer read request
// - fetch_buf_rd_req_addr  out PAYLOAD_PTR_W     byte address, copied from payload.addr
// - fetch_buf_rd_req_size  out PAYLOAD_PTR_W+1   byte count, copied from payload.size
// - fetch_buf_rd_req_rdy   in  1
// - buf_fetch_rd_resp_val  in  1                 read response beat
// - buf_fetch_rd_resp_data in  DATA_W            beat data, first byte in MSBs
// - fetch_buf_rd_resp_rdy  out 1
// - fetch_data_val      out  1                   payload beat valid
// - fetch_data          out  DATA_W              payload beat
// - fetch_data_last     out  1                   final beat of packet
// - fetch_data_padbytes out  BYTES_W             invalid trailing bytes on last beat; 0 otherwise
// - fetch_data_rdy      in   1
// BEHAVIOUR
// - Reset (rst==0, async): state=IDLE, all *_val outputs 0, tx_pkt_hdr_rdy 0 during reset,
//   beat counter 0, registers cleared. A packet in flight when reset asserts is dropped; no partial stream resumes.
// - Handshake: transfer when val&&rdy on the same cycle. A val, once raised, holds with stable data until rdy.
//   No comb path from any rdy input to a val output.
// - FSM states and transitions:
//   - IDLE: tx_pkt_hdr_rdy=1. On accept, register all fields, compute nbeats, go to META.
//   - META: fetch_meta_val=1. On meta handshake: go to IDLE if size==0, else go to REQ.
//   - REQ: fetch_buf_rd_req_val=1. On rd_req handshake, go to DATA with beat_cnt=nbeats-1.
//   - DATA: fetch_data_val=buf_fetch_rd_resp_val; fetch_buf_rd_resp_rdy=fetch_data_rdy (pass-through, 0 latency).
//     Each beat handshake decrements beat_cnt. The beat with beat_cnt==0 drives fetch_data_last=1; after it, go to IDLE.
// - Arithmetic: B=DATA_W/8. nbeats=ceil(size/B)=(size+B-1)>>log2(B), computed in PAYLOAD_PTR_W+2 bits (no overflow at max size).
//   padbytes=(B - size[BYTES_W-1:0]) mod B, applied on the last beat only. payload_len=size.
// - Latency: descriptor accept -> meta_val is 1 cycle. Meta handshake -> rd_req_val is 1 cycle.
//   Throughput is 1 beat/cycle in DATA.
// - Boundaries:
//   - size==0: no read request and no data beats issued; meta is still sent.
//   - size an exact multiple of B: padbytes=0 on the last beat.
//   - size<B: single beat, last=1.
//   - Response beats arriving outside DATA are not accepted (rd_resp_rdy=0).
//   - Back-to-back packets: the next descriptor is accepted on the cycle after the last beat (IDLE); no bubble beyond that.
// STRUCTURE
// - tcp_misc_pkg gets tx_meta_struct, TX_META_STRUCT_W and the beat-count helper function ceil_beats(size, B).
//   payload_buf_struct and tcp_pkt_hdr stay where already defined.
// - Split as tcp_tx_payload_fetch_ctrl (FSM, beat counter, val/rdy) plus tcp_tx_payload_fetch_datap (descriptor regs, nbeats/padbytes).
//   This is the same ctrl/datap split used across the TX path.
// TESTING
// - size=0, addr=0x100: one meta with payload_len=0; zero rd_req; zero data beats; hdr_rdy high again 2 cycles after accept.
// - DATA_W=512, size=64: rd_req addr/size echoed; exactly 1 beat, last=1, padbytes=0.
// - size=130: 3 beats; last on the 3rd; padbytes=62; beats 1-2 have padbytes=0.
// - fetch_data_rdy toggled randomly during a 10-beat packet: no beat lost or duplicated;
//   data matches the response order; val/data stable while stalled.
// - Two descriptors offered back-to-back with fetch_meta_rdy held low 5 cycles:
//   the second is not accepted until the first's last beat completes; metas arrive in order.
// - rst driven low mid-DATA (beat 2 of 4), then released: all vals 0 immediately; state IDLE;
//   the next packet is fetched correctly from scratch.

Source files
------------

// File: rtl/tcp_misc_pkg.sv
// Shared TCP TX-path types: header/buffer descriptors, fetch metadata and beat-count helper.
package tcp_misc_pkg;

  localparam int unsigned FLOWID_W       = 16;
  localparam int unsigned IP_ADDR_W      = 32;
  localparam int unsigned PAYLOAD_PTR_W  = 16;
  localparam int unsigned PAYLOAD_SIZE_W = PAYLOAD_PTR_W + 1;
  // One extra bit so size + B - 1 cannot overflow at maximum size.
  localparam int unsigned NBEATS_W       = PAYLOAD_PTR_W + 2;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [7:0]  flags;
    logic [15:0] win_size;
  } tcp_pkt_hdr;
  localparam int unsigned TCP_PKT_HDR_W = $bits(tcp_pkt_hdr);

  typedef struct packed {
    logic [PAYLOAD_PTR_W-1:0]  addr;
    logic [PAYLOAD_SIZE_W-1:0] size;
  } payload_buf_struct;
  localparam int unsigned PAYLOAD_BUF_STRUCT_W = $bits(payload_buf_struct);

  typedef struct packed {
    logic [FLOWID_W-1:0]       flowid;
    tcp_pkt_hdr                hdr;
    logic [IP_ADDR_W-1:0]      src_ip;
    logic [IP_ADDR_W-1:0]      dst_ip;
    logic [PAYLOAD_SIZE_W-1:0] payload_len;
  } tx_meta_struct;
  localparam int unsigned TX_META_STRUCT_W = $bits(tx_meta_struct);

  typedef enum logic [1:0] {StIdle, StMeta, StReq, StData} fetch_state_e;

  // b must be a power of two so the divide reduces to a shift.
  function automatic logic [NBEATS_W-1:0] ceil_beats(input logic [PAYLOAD_SIZE_W-1:0] size,
                                                     input int unsigned b);
    logic [NBEATS_W-1:0] ext;
    ext = NBEATS_W'(size) + NBEATS_W'(b - 1);
    return ext / NBEATS_W'(b);
  endfunction

endpackage

// File: rtl/tcp_tx_payload_fetch_ctrl.sv
// Fetch sequencing FSM: descriptor -> metadata -> buffer read request -> payload beats.
module tcp_tx_payload_fetch_ctrl
  import tcp_misc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                hdr_val_i,
  output logic                hdr_rdy_o,
  output logic                accept_o,
  output logic                meta_val_o,
  input  logic                meta_rdy_i,
  input  logic                size_zero_i,
  input  logic [NBEATS_W-1:0] nbeats_i,
  output logic                req_val_o,
  input  logic                req_rdy_i,
  input  logic                resp_val_i,
  output logic                resp_rdy_o,
  output logic                data_val_o,
  input  logic                data_rdy_i,
  output logic                last_o
);

  fetch_state_e        state_q, state_d;
  logic [NBEATS_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                hdr_rdy_q, meta_val_q, req_val_q, in_data_q;
  logic                beat_fire;

  assign accept_o  = hdr_val_i & hdr_rdy_q;
  assign beat_fire = in_data_q & resp_val_i & data_rdy_i;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: if (accept_o) state_d = StMeta;
      StMeta: if (meta_val_q && meta_rdy_i) state_d = size_zero_i ? StIdle : StReq;
      StReq: begin
        if (req_val_q && req_rdy_i) begin
          state_d    = StData;
          beat_cnt_d = nbeats_i - NBEATS_W'(1);
        end
      end
      StData: begin
        if (beat_fire) begin
          if (beat_cnt_q == '0) state_d = StIdle;
          else beat_cnt_d = beat_cnt_q - NBEATS_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake flags are registered from the next state so no rdy input reaches a val output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      hdr_rdy_q  <= 1'b0;
      meta_val_q <= 1'b0;
      req_val_q  <= 1'b0;
      in_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      hdr_rdy_q  <= (state_d == StIdle);
      meta_val_q <= (state_d == StMeta);
      req_val_q  <= (state_d == StReq);
      in_data_q  <= (state_d == StData);
    end
  end

  assign hdr_rdy_o  = hdr_rdy_q;
  assign meta_val_o = meta_val_q;
  assign req_val_o  = req_val_q;
  assign resp_rdy_o = in_data_q & data_rdy_i;
  assign data_val_o = in_data_q & resp_val_i;
  assign last_o     = in_data_q & (beat_cnt_q == '0);

endmodule

// File: rtl/tcp_tx_payload_fetch_datap.sv
// Descriptor registers plus per-packet beat count and last-beat pad computation.
module tcp_tx_payload_fetch_datap
  import tcp_misc_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  localparam int unsigned BYTES_W = $clog2(DATA_W / 8)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      accept_i,
  input  logic [FLOWID_W-1:0]       flowid_i,
  input  tcp_pkt_hdr                hdr_i,
  input  logic [IP_ADDR_W-1:0]      src_ip_i,
  input  logic [IP_ADDR_W-1:0]      dst_ip_i,
  input  payload_buf_struct         payload_i,
  output tx_meta_struct             meta_o,
  output logic [PAYLOAD_PTR_W-1:0]  rd_addr_o,
  output logic [PAYLOAD_SIZE_W-1:0] rd_size_o,
  output logic [NBEATS_W-1:0]       nbeats_o,
  output logic [BYTES_W-1:0]        padbytes_o,
  output logic                      size_zero_o
);

  tx_meta_struct            meta_q, meta_d;
  logic [PAYLOAD_PTR_W-1:0] addr_q, addr_d;
  logic [NBEATS_W-1:0]      nbeats_q, nbeats_d;
  logic [BYTES_W-1:0]       pad_q, pad_d;

  always_comb begin
    meta_d   = meta_q;
    addr_d   = addr_q;
    nbeats_d = nbeats_q;
    pad_d    = pad_q;
    if (accept_i) begin
      meta_d.flowid      = flowid_i;
      meta_d.hdr         = hdr_i;
      meta_d.src_ip      = src_ip_i;
      meta_d.dst_ip      = dst_ip_i;
      meta_d.payload_len = payload_i.size;
      addr_d             = payload_i.addr;
      nbeats_d           = ceil_beats(payload_i.size, DATA_W / 8);
      // Two's-complement of the low bits is (B - size) mod B.
      pad_d              = BYTES_W'(0) - payload_i.size[BYTES_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q   <= '0;
      addr_q   <= '0;
      nbeats_q <= '0;
      pad_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      addr_q   <= addr_d;
      nbeats_q <= nbeats_d;
      pad_q    <= pad_d;
    end
  end

  assign meta_o      = meta_q;
  assign rd_addr_o   = addr_q;
  assign rd_size_o   = meta_q.payload_len;
  assign nbeats_o    = nbeats_q;
  assign padbytes_o  = pad_q;
  assign size_zero_o = (meta_q.payload_len == '0);

endmodule

// File: rtl/tcp_tx_payload_fetch.sv
// TCP TX payload fetch: forwards header metadata, then streams the packet payload from the buffer.
module tcp_tx_payload_fetch
  import tcp_misc_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  localparam int unsigned BYTES_W = $clog2(DATA_W / 8)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        tx_pkt_hdr_val_i,
  input  logic [FLOWID_W-1:0]         tx_pkt_flowid_i,
  input  tcp_pkt_hdr                  tx_pkt_hdr_i,
  input  logic [IP_ADDR_W-1:0]        tx_pkt_src_ip_addr_i,
  input  logic [IP_ADDR_W-1:0]        tx_pkt_dst_ip_addr_i,
  input  payload_buf_struct           tx_pkt_payload_i,
  output logic                        tx_pkt_hdr_rdy_o,
  output logic                        fetch_meta_val_o,
  output tx_meta_struct               fetch_meta_data_o,
  input  logic                        fetch_meta_rdy_i,
  output logic                        fetch_buf_rd_req_val_o,
  output logic [PAYLOAD_PTR_W-1:0]    fetch_buf_rd_req_addr_o,
  output logic [PAYLOAD_SIZE_W-1:0]   fetch_buf_rd_req_size_o,
  input  logic                        fetch_buf_rd_req_rdy_i,
  input  logic                        buf_fetch_rd_resp_val_i,
  input  logic [DATA_W-1:0]           buf_fetch_rd_resp_data_i,
  output logic                        fetch_buf_rd_resp_rdy_o,
  output logic                        fetch_data_val_o,
  output logic [DATA_W-1:0]           fetch_data_o,
  output logic                        fetch_data_last_o,
  output logic [BYTES_W-1:0]          fetch_data_padbytes_o,
  input  logic                        fetch_data_rdy_i
);

  logic                accept;
  logic                size_zero;
  logic [NBEATS_W-1:0] nbeats;
  logic [BYTES_W-1:0]  padbytes;
  logic                last;

  tcp_tx_payload_fetch_ctrl u_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .hdr_val_i   (tx_pkt_hdr_val_i),
    .hdr_rdy_o   (tx_pkt_hdr_rdy_o),
    .accept_o    (accept),
    .meta_val_o  (fetch_meta_val_o),
    .meta_rdy_i  (fetch_meta_rdy_i),
    .size_zero_i (size_zero),
    .nbeats_i    (nbeats),
    .req_val_o   (fetch_buf_rd_req_val_o),
    .req_rdy_i   (fetch_buf_rd_req_rdy_i),
    .resp_val_i  (buf_fetch_rd_resp_val_i),
    .resp_rdy_o  (fetch_buf_rd_resp_rdy_o),
    .data_val_o  (fetch_data_val_o),
    .data_rdy_i  (fetch_data_rdy_i),
    .last_o      (last)
  );

  tcp_tx_payload_fetch_datap #(
    .DATA_W (DATA_W)
  ) u_datap (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .accept_i    (accept),
    .flowid_i    (tx_pkt_flowid_i),
    .hdr_i       (tx_pkt_hdr_i),
    .src_ip_i    (tx_pkt_src_ip_addr_i),
    .dst_ip_i    (tx_pkt_dst_ip_addr_i),
    .payload_i   (tx_pkt_payload_i),
    .meta_o      (fetch_meta_data_o),
    .rd_addr_o   (fetch_buf_rd_req_addr_o),
    .rd_size_o   (fetch_buf_rd_req_size_o),
    .nbeats_o    (nbeats),
    .padbytes_o  (padbytes),
    .size_zero_o (size_zero)
  );

  assign fetch_data_o          = buf_fetch_rd_resp_data_i;
  assign fetch_data_last_o     = last;
  assign fetch_data_padbytes_o = last ? padbytes : '0;

endmodule

// File: tb/tb_tcp_tx_payload_fetch.sv
// Scoreboard bench for tcp_tx_payload_fetch with a behavioural payload-buffer responder.
module tb_tcp_tx_payload_fetch;
  import tcp_misc_pkg::*;

  localparam int unsigned DataW  = 512;
  localparam int unsigned B      = DataW / 8;
  localparam int unsigned BytesW = $clog2(B);

  typedef struct packed {
    logic [DataW-1:0]  data;
    logic              last;
    logic [BytesW-1:0] pad;
  } beat_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                      hdr_val = 1'b0;
  logic [FLOWID_W-1:0]       flowid = '0;
  tcp_pkt_hdr                hdr = '0;
  logic [IP_ADDR_W-1:0]      src_ip = '0;
  logic [IP_ADDR_W-1:0]      dst_ip = '0;
  payload_buf_struct         payload = '0;
  logic                      hdr_rdy;
  logic                      meta_val;
  tx_meta_struct             meta_data;
  logic                      meta_rdy = 1'b1;
  logic                      req_val;
  logic [PAYLOAD_PTR_W-1:0]  req_addr;
  logic [PAYLOAD_SIZE_W-1:0] req_size;
  logic                      req_rdy = 1'b1;
  logic                      resp_val = 1'b0;
  logic [DataW-1:0]          resp_data = '0;
  logic                      resp_rdy;
  logic                      data_val;
  logic [DataW-1:0]          data;
  logic                      data_last;
  logic [BytesW-1:0]         data_pad;
  logic                      data_rdy = 1'b1;

  tcp_tx_payload_fetch #(
    .DATA_W (DataW)
  ) dut (
    .clk_i                    (clk_i),
    .rst_ni                   (rst_ni),
    .tx_pkt_hdr_val_i         (hdr_val),
    .tx_pkt_flowid_i          (flowid),
    .tx_pkt_hdr_i             (hdr),
    .tx_pkt_src_ip_addr_i     (src_ip),
    .tx_pkt_dst_ip_addr_i     (dst_ip),
    .tx_pkt_payload_i         (payload),
    .tx_pkt_hdr_rdy_o         (hdr_rdy),
    .fetch_meta_val_o         (meta_val),
    .fetch_meta_data_o        (meta_data),
    .fetch_meta_rdy_i         (meta_rdy),
    .fetch_buf_rd_req_val_o   (req_val),
    .fetch_buf_rd_req_addr_o  (req_addr),
    .fetch_buf_rd_req_size_o  (req_size),
    .fetch_buf_rd_req_rdy_i   (req_rdy),
    .buf_fetch_rd_resp_val_i  (resp_val),
    .buf_fetch_rd_resp_data_i (resp_data),
    .fetch_buf_rd_resp_rdy_o  (resp_rdy),
    .fetch_data_val_o         (data_val),
    .fetch_data_o             (data),
    .fetch_data_last_o        (data_last),
    .fetch_data_padbytes_o    (data_pad),
    .fetch_data_rdy_i         (data_rdy)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [DataW-1:0] got,
                          input logic [DataW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DataW-1:0] beat_data(input logic [PAYLOAD_PTR_W-1:0] addr,
                                                 input int idx);
    logic [DataW-1:0] d;
    for (int w = 0; w < int'(DataW / 32); w++)
      d[w*32 +: 32] = {addr, 16'(idx)} ^ (32'(w) * 32'h9E3779B1);
    return d;
  endfunction

  tx_meta_struct    exp_meta_q[$];
  logic [32:0]      exp_req_q[$];
  beat_t            exp_beat_q[$];
  logic [DataW-1:0] resp_q[$];

  int   meta_seen = 0;
  int   req_seen  = 0;
  int   beat_seen = 0;
  logic resp_fired = 1'b0;
  logic stall_prev = 1'b0;
  logic [DataW-1:0] stall_data = '0;
  logic rand_rdy = 1'b0;

  // Handshakes seen here complete on the following rising edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (hdr_val && hdr_rdy) begin
        tx_meta_struct m;
        int nb;
        check_eq("accept_while_busy",
                 DataW'(exp_meta_q.size() + exp_req_q.size() + exp_beat_q.size()), '0);
        m.flowid = flowid; m.hdr = hdr; m.src_ip = src_ip; m.dst_ip = dst_ip;
        m.payload_len = payload.size;
        exp_meta_q.push_back(m);
        if (payload.size != 0) begin
          exp_req_q.push_back({payload.addr, payload.size});
          nb = (int'(payload.size) + int'(B) - 1) / int'(B);
          for (int i = 0; i < nb; i++) begin
            beat_t bt;
            bt.data = beat_data(payload.addr, i);
            bt.last = (i == nb - 1);
            bt.pad  = (i == nb - 1) ? BytesW'((B - (int'(payload.size) % B)) % B) : '0;
            exp_beat_q.push_back(bt);
          end
        end
      end
      if (meta_val && meta_rdy) begin
        meta_seen++;
        if (exp_meta_q.size() == 0) check_eq("meta_unexpected", DataW'(1), DataW'(0));
        else check_eq("meta", DataW'(meta_data), DataW'(exp_meta_q.pop_front()));
      end
      if (req_val && req_rdy) begin
        req_seen++;
        if (exp_req_q.size() == 0) check_eq("req_unexpected", DataW'(1), DataW'(0));
        else check_eq("rd_req", DataW'({req_addr, req_size}), DataW'(exp_req_q.pop_front()));
        for (int i = 0; i < (int'(req_size) + int'(B) - 1) / int'(B); i++)
          resp_q.push_back(beat_data(req_addr, i));
      end
      if (resp_val && resp_rdy) resp_fired = 1'b1;
      if (data_val && data_rdy) begin
        beat_seen++;
        if (exp_beat_q.size() == 0) check_eq("beat_unexpected", DataW'(1), DataW'(0));
        else begin
          beat_t bt;
          bt = exp_beat_q.pop_front();
          check_eq("beat_data", data, bt.data);
          check_eq("beat_last", DataW'(data_last), DataW'(bt.last));
          check_eq("beat_pad", DataW'(data_pad), DataW'(bt.pad));
        end
      end
      if (stall_prev) begin
        check_eq("stall_val", DataW'(data_val), DataW'(1'b1));
        check_eq("stall_data", data, stall_data);
      end
      stall_prev = data_val && !data_rdy;
      stall_data = data;
    end
  end

  // Payload buffer responder and downstream ready generator.
  initial forever begin
    @(posedge clk_i);
    #1;
    if (resp_fired && resp_q.size() > 0) void'(resp_q.pop_front());
    resp_fired = 1'b0;
    resp_val   = (resp_q.size() > 0);
    resp_data  = (resp_q.size() > 0) ? resp_q[0] : '0;
    data_rdy   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Caller is aligned just after a rising edge; returns just after the accepting edge.
  task automatic send_desc(input logic [FLOWID_W-1:0] f, input logic [PAYLOAD_PTR_W-1:0] a,
                           input logic [PAYLOAD_SIZE_W-1:0] s);
    int waited = 0;
    hdr_val = 1'b1;
    flowid  = f;
    hdr = '0;
    hdr.src_port = 16'h1000 + 16'(f);
    hdr.dst_port = 16'h0050;
    hdr.seq_num  = {f, a};
    hdr.flags    = 8'h18;
    src_ip       = 32'h0A00_0001;
    dst_ip       = 32'h0A00_0100 + 32'(f);
    payload.addr = a;
    payload.size = s;
    forever begin
      @(negedge clk_i);
      if (hdr_rdy) break;
      waited++;
      if (waited > 500) begin
        check_eq("hdr_accept_timeout", DataW'(0), DataW'(1));
        break;
      end
    end
    @(posedge clk_i);
    #1;
    hdr_val = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    forever begin
      @(negedge clk_i);
      #1;
      if (hdr_rdy && exp_meta_q.size() == 0 && exp_req_q.size() == 0 &&
          exp_beat_q.size() == 0) break;
      waited++;
      if (waited > 2000) begin
        check_eq("idle_timeout", DataW'(0), DataW'(1));
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  int m0, r0, b0;

  initial begin
    #2;
    check_eq("rst_hdr_rdy", DataW'(hdr_rdy), '0);
    check_eq("rst_meta_val", DataW'(meta_val), '0);
    check_eq("rst_req_val", DataW'(req_val), '0);
    check_eq("rst_data_val", DataW'(data_val), '0);
    check_eq("rst_resp_rdy", DataW'(resp_rdy), '0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Zero-length payload: metadata only.
    m0 = meta_seen; r0 = req_seen; b0 = beat_seen;
    send_desc(16'd1, 16'h0100, 17'd0);
    @(negedge clk_i);
    check_eq("z_meta_val", DataW'(meta_val), DataW'(1'b1));
    check_eq("z_hdr_rdy_c1", DataW'(hdr_rdy), '0);
    check_eq("z_resp_rdy_meta", DataW'(resp_rdy), '0);
    @(negedge clk_i);
    check_eq("z_hdr_rdy_c2", DataW'(hdr_rdy), DataW'(1'b1));
    wait_idle();
    check_eq("z_meta_cnt", DataW'(meta_seen - m0), DataW'(1));
    check_eq("z_req_cnt", DataW'(req_seen - r0), '0);
    check_eq("z_beat_cnt", DataW'(beat_seen - b0), '0);

    // Exactly one full beat, then three beats with a partial tail.
    m0 = meta_seen; r0 = req_seen; b0 = beat_seen;
    send_desc(16'd2, 16'h2000, 17'd64);
    wait_idle();
    check_eq("b64_req_cnt", DataW'(req_seen - r0), DataW'(1));
    check_eq("b64_beat_cnt", DataW'(beat_seen - b0), DataW'(1));
    b0 = beat_seen;
    send_desc(16'd3, 16'h3040, 17'd130);
    wait_idle();
    check_eq("b130_beat_cnt", DataW'(beat_seen - b0), DataW'(3));

    // Ten beats with random downstream backpressure.
    b0 = beat_seen;
    rand_rdy = 1'b1;
    send_desc(16'd4, 16'h5000, 17'd635);
    wait_idle();
    rand_rdy = 1'b0;
    check_eq("rand_beat_cnt", DataW'(beat_seen - b0), DataW'(10));

    // Back-to-back descriptors while metadata is held off.
    m0 = meta_seen; b0 = beat_seen;
    meta_rdy = 1'b0;
    fork
      begin
        send_desc(16'd5, 16'h6000, 17'd200);
        send_desc(16'd6, 16'h7000, 17'd10);
      end
      begin
        repeat (5) @(posedge clk_i);
        #1;
        meta_rdy = 1'b1;
      end
    join
    wait_idle();
    check_eq("b2b_meta_cnt", DataW'(meta_seen - m0), DataW'(2));
    check_eq("b2b_beat_cnt", DataW'(beat_seen - b0), DataW'(5));

    // Reset in the middle of a four-beat payload.
    b0 = beat_seen;
    send_desc(16'd7, 16'h4000, 17'd256);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      #1;
      if (beat_seen - b0 >= 2) break;
    end
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_data_val", DataW'(data_val), '0);
    check_eq("mid_rst_meta_val", DataW'(meta_val), '0);
    check_eq("mid_rst_req_val", DataW'(req_val), '0);
    check_eq("mid_rst_hdr_rdy", DataW'(hdr_rdy), '0);
    check_eq("mid_rst_resp_rdy", DataW'(resp_rdy), '0);
    exp_meta_q.delete();
    exp_req_q.delete();
    exp_beat_q.delete();
    resp_q.delete();
    resp_fired = 1'b0;
    stall_prev = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("post_rst_hdr_rdy", DataW'(hdr_rdy), DataW'(1'b1));
    check_eq("post_rst_data_val", DataW'(data_val), '0);
    b0 = beat_seen;
    send_desc(16'd8, 16'h0800, 17'd100);
    wait_idle();
    check_eq("post_rst_beat_cnt", DataW'(beat_seen - b0), DataW'(2));

    check_eq("sb_empty", DataW'(exp_meta_q.size() + exp_req_q.size() + exp_beat_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
